// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_stage_pkg;

    localparam int XLEN = 32;

    // addi x0,x0,0 -- the bubble placed in IF/ID whenever it holds no real instruction
    localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0013;

    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    // True when an address is word aligned and may be loaded into the PC.
    function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a small
// sequencing FSM. Instruction memory lives outside and answers combinationally.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   BOOT  | first cycle after reset release; PC parked at RESET_PC, no capture
//   RUN   | normal fetch; honours redirect (highest priority) and stall
//   HALT  | misaligned redirect seen; everything frozen until reset
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_WORD
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            id_valid_o,
    output logic [XLEN-1:0] id_instr_o,
    output logic [XLEN-1:0] id_pc_o,
    output logic [XLEN-1:0] id_pc_plus4_o,
    output logic            fault_o
);

    // Low PC bits are forced to zero so the PC can never become misaligned,
    // even if a misaligned RESET_PC is supplied.
    localparam logic [XLEN-1:0] RESET_PC_ALIGNED = {RESET_PC[XLEN-1:2], 2'b00};

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] id_pc_q, id_pc_d;
    logic [XLEN-1:0] id_pc_plus4_q, id_pc_plus4_d;
    logic            fault_q, fault_d;
    logic [XLEN-1:0] pc_plus4;

    // Sequential PC arithmetic wraps modulo 2^32 by width.
    assign pc_plus4 = pc_q + PC_STEP;

    // State, PC and IF/ID registers; reset clears them asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC_ALIGNED;
            valid_q       <= 1'b0;
            instr_q       <= NOP_INSTR;
            id_pc_q       <= '0;
            id_pc_plus4_q <= '0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            valid_q       <= valid_d;
            instr_q       <= instr_d;
            id_pc_q       <= id_pc_d;
            id_pc_plus4_q <= id_pc_plus4_d;
            fault_q       <= fault_d;
        end
    end

    // Next-state and next-register logic; everything holds unless RUN says otherwise.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        valid_d       = valid_q;
        instr_d       = instr_q;
        id_pc_d       = id_pc_q;
        id_pc_plus4_d = id_pc_plus4_q;
        fault_d       = fault_q;

        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (redirect_i) begin
                    // The word fetched this cycle is on the wrong path: squash it.
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                    if (is_word_aligned(redirect_pc_i)) begin
                        pc_d = redirect_pc_i;
                    end else begin
                        fault_d = 1'b1;
                        state_d = HALT;
                    end
                end else if (!stall_i) begin
                    valid_d       = 1'b1;
                    instr_d       = imem_rdata;
                    id_pc_d       = pc_q;
                    id_pc_plus4_d = pc_plus4;
                    pc_d          = pc_plus4;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    assign imem_addr     = pc_q;
    assign id_valid_o    = valid_q;
    assign id_instr_o    = instr_q;
    assign id_pc_o       = id_pc_q;
    assign id_pc_plus4_o = id_pc_plus4_q;
    assign fault_o       = fault_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a table of per-edge vectors plus a few
// hand-written sequences around reset and a wrap-around RESET_PC instance.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;

    logic [31:0] imem_addr_a, imem_rdata_a;
    logic        id_valid_a, fault_a;
    logic [31:0] id_instr_a, id_pc_a, id_pc_plus4_a;

    logic [31:0] imem_addr_b, imem_rdata_b;
    logic        id_valid_b, fault_b;
    logic [31:0] id_instr_b, id_pc_b, id_pc_plus4_b;
    logic        stall_b, redirect_b;
    logic [31:0] redirect_pc_b;

    int n_total;
    int n_pass;

    // Instruction memory model: every word is its address xor a fixed tag.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    assign imem_rdata_a = mem_word(imem_addr_a);
    assign imem_rdata_b = mem_word(imem_addr_b);

    fetch_stage dut_a (
        .clk           (clk),
        .rst           (rst),
        .imem_addr     (imem_addr_a),
        .imem_rdata    (imem_rdata_a),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .id_valid_o    (id_valid_a),
        .id_instr_o    (id_instr_a),
        .id_pc_o       (id_pc_a),
        .id_pc_plus4_o (id_pc_plus4_a),
        .fault_o       (fault_a)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
        .clk           (clk),
        .rst           (rst),
        .imem_addr     (imem_addr_b),
        .imem_rdata    (imem_rdata_b),
        .stall_i       (stall_b),
        .redirect_i    (redirect_b),
        .redirect_pc_i (redirect_pc_b),
        .id_valid_o    (id_valid_b),
        .id_instr_o    (id_instr_b),
        .id_pc_o       (id_pc_b),
        .id_pc_plus4_o (id_pc_plus4_b),
        .fault_o       (fault_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk_a(input string tag, input logic valid, input logic [31:0] instr,
                         input logic [31:0] pc, input logic [31:0] plus4,
                         input logic [31:0] addr, input logic fault);
        chk({tag, ".valid"}, {31'd0, id_valid_a}, {31'd0, valid});
        chk({tag, ".instr"}, id_instr_a, instr);
        chk({tag, ".pc"}, id_pc_a, pc);
        chk({tag, ".pc4"}, id_pc_plus4_a, plus4);
        chk({tag, ".addr"}, imem_addr_a, addr);
        chk({tag, ".fault"}, {31'd0, fault_a}, {31'd0, fault});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        string       name;
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] plus4;
        logic [31:0] addr;
        logic        fault;
    } vec_t;

    vec_t vecs[15];

    initial begin
        n_total = 0;
        n_pass  = 0;

        //              name        stl rdr rpc            vld instr           pc             pc+4           addr           flt
        vecs[0]  = '{"boot",        0, 0, 32'h0,        0, NOP,            32'h0,         32'h0,         32'h0,         0};
        vecs[1]  = '{"w0",          0, 0, 32'h0,        1, 32'hC0DE_0000,  32'h0,         32'h4,         32'h4,         0};
        vecs[2]  = '{"w1",          0, 0, 32'h0,        1, 32'hC0DE_0004,  32'h4,         32'h8,         32'h8,         0};
        vecs[3]  = '{"stall1",      1, 0, 32'h0,        1, 32'hC0DE_0004,  32'h4,         32'h8,         32'h8,         0};
        vecs[4]  = '{"stall2",      1, 0, 32'h0,        1, 32'hC0DE_0004,  32'h4,         32'h8,         32'h8,         0};
        vecs[5]  = '{"stall3",      1, 0, 32'h0,        1, 32'hC0DE_0004,  32'h4,         32'h8,         32'h8,         0};
        vecs[6]  = '{"w2",          0, 0, 32'h0,        1, 32'hC0DE_0008,  32'h8,         32'hC,         32'hC,         0};
        vecs[7]  = '{"redir_stl",   1, 1, 32'h40,       0, NOP,            32'h8,         32'hC,         32'h40,        0};
        vecs[8]  = '{"at40",        0, 0, 32'h0,        1, 32'hC0DE_0040,  32'h40,        32'h44,        32'h44,        0};
        vecs[9]  = '{"at44",        0, 0, 32'h0,        1, 32'hC0DE_0044,  32'h44,        32'h48,        32'h48,        0};
        vecs[10] = '{"redir100",    0, 1, 32'h100,      0, NOP,            32'h44,        32'h48,        32'h100,       0};
        vecs[11] = '{"at100",       0, 0, 32'h0,        1, 32'hC0DE_0100,  32'h100,       32'h104,       32'h104,       0};
        vecs[12] = '{"misalign",    0, 1, 32'h42,       0, NOP,            32'h100,       32'h104,       32'h104,       1};
        vecs[13] = '{"halt_redir",  0, 1, 32'h80,       0, NOP,            32'h100,       32'h104,       32'h104,       1};
        vecs[14] = '{"halt_run",    1, 0, 32'h0,        0, NOP,            32'h100,       32'h104,       32'h104,       1};

        rst           = 1'b0;
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        stall_b       = 1'b0;
        redirect_b    = 1'b0;
        redirect_pc_b = '0;

        step();
        step();
        chk_a("rst", 0, NOP, 32'h0, 32'h0, 32'h0, 0);
        chk("rst.b_addr", imem_addr_b, 32'hFFFF_FFFC);

        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 15; i++) begin
            stall_i       = vecs[i].stall;
            redirect_i    = vecs[i].redir;
            redirect_pc_i = vecs[i].rpc;
            step();
            chk_a(vecs[i].name, vecs[i].valid, vecs[i].instr, vecs[i].pc,
                  vecs[i].plus4, vecs[i].addr, vecs[i].fault);
        end

        // Reset while halted clears the sticky fault without any clock edge.
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_a("halt_rst", 0, NOP, 32'h0, 32'h0, 32'h0, 0);

        stall_i    = 1'b0;
        redirect_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        step();
        chk_a("reboot", 0, NOP, 32'h0, 32'h0, 32'h0, 0);
        chk("wrap.boot_valid", {31'd0, id_valid_b}, 32'd0);
        chk("wrap.boot_addr", imem_addr_b, 32'hFFFF_FFFC);

        step();
        chk_a("re_w0", 1, 32'hC0DE_0000, 32'h0, 32'h4, 32'h4, 0);
        chk("wrap.pc", id_pc_b, 32'hFFFF_FFFC);
        chk("wrap.pc4", id_pc_plus4_b, 32'h0);
        chk("wrap.addr", imem_addr_b, 32'h0);
        chk("wrap.instr", id_instr_b, 32'h3F21_FFFC);
        chk("wrap.valid", {31'd0, id_valid_b}, 32'd1);

        step();
        chk_a("re_w1", 1, 32'hC0DE_0004, 32'h4, 32'h8, 32'h8, 0);

        // Reset dropped between edges while running.
        #2;
        rst = 1'b0;
        #1;
        chk_a("mid_rst", 0, NOP, 32'h0, 32'h0, 32'h0, 0);
        chk("mid_rst.b_pc", id_pc_b, 32'h0);
        chk("mid_rst.b_addr", imem_addr_b, 32'hFFFF_FFFC);

        step();
        chk_a("held_rst", 0, NOP, 32'h0, 32'h0, 32'h0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
